// File: rtl/sysid_regbank_uptime.sv
// System-ID register bank with a prescaled uptime counter.
// Avalon-MM slave: identity words, scratch, coherent 64-bit uptime snapshot.
//
// Ports:
//   clock          system clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   address[2:0]   word address
//   read, write    Avalon strobes, no waitrequest; read wins over write
//   writedata[31:0]
//   readdata[31:0] registered read data, latency 1
//   readdatavalid  high one cycle after an accepted read
//
// Register map:
//   0 ID  1 TIMESTAMP  2 BUILD_INFO  3 SCRATCH (R/W)
//   4 UPTIME_LO (captures high word into shadow)  5 UPTIME_HI (shadow)
//   6 CTRL: bit0 enable (R/W), bit1 clear (write-1 pulse)  7 reserved
//
// UPTIME_W must lie in 33..64 and PRESCALE in 1..65535.

module sysid_regbank_uptime #(
    parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
    parameter logic [31:0] SYSID_TIMESTAMP = 32'h0000_0000,
    parameter logic [31:0] BUILD_INFO      = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000,
    parameter int unsigned UPTIME_W        = 64,
    parameter int unsigned PRESCALE        = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int PW = 16;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_TSTAMP  = 3'd1;
    localparam logic [2:0] A_BUILD   = 3'd2;
    localparam logic [2:0] A_SCRATCH = 3'd3;
    localparam logic [2:0] A_UP_LO   = 3'd4;
    localparam logic [2:0] A_UP_HI   = 3'd5;
    localparam logic [2:0] A_CTRL    = 3'd6;

    logic [PW-1:0]       presc;
    logic [UPTIME_W-1:0] uptime;
    logic [31:0]         hi_shadow;
    logic [31:0]         scratch;
    logic                enable;

    logic                wr_acc;
    logic                clr;
    logic                tick;
    logic [63:0]         up_ext;
    logic [31:0]         rd_mux;

    // A write coinciding with a read is dropped.
    always_comb begin
        wr_acc = write & ~read;
        clr    = wr_acc && (address == A_CTRL) && writedata[1];
        tick   = enable && (presc == PRESC_MAX);
        // Zero-extend so the high word is well defined for any width.
        up_ext = 64'(uptime);
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            A_ID:      rd_mux = SYSID_ID;
            A_TSTAMP:  rd_mux = SYSID_TIMESTAMP;
            A_BUILD:   rd_mux = BUILD_INFO;
            A_SCRATCH: rd_mux = scratch;
            A_UP_LO:   rd_mux = up_ext[31:0];
            A_UP_HI:   rd_mux = hi_shadow;
            A_CTRL:    rd_mux = {31'b0, enable};
            default:   rd_mux = '0;
        endcase
    end

    // Bus side: registered read port, scratch and control.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            hi_shadow     <= '0;
            scratch       <= SCRATCH_RESET;
            enable        <= 1'b1;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
                // Snapshot the pre-increment high word alongside the low word.
                if (address == A_UP_LO) begin
                    hi_shadow <= up_ext[63:32];
                end
            end
            if (wr_acc && (address == A_SCRATCH)) begin
                scratch <= writedata;
            end
            if (wr_acc && (address == A_CTRL)) begin
                enable <= writedata[0];
            end
        end
    end

    // Uptime: prescaler divides the clock, counter wraps silently.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc  <= '0;
            uptime <= '0;
        end else if (clr) begin
            presc  <= '0;
            uptime <= '0;
        end else if (enable) begin
            if (tick) begin
                presc  <= '0;
                uptime <= uptime + UPTIME_W'(1);
            end else begin
                presc  <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sysid_regbank_uptime.sv
// Testbench for sysid_regbank_uptime: two instances on one bus,
// checked against a cycle-count reference model plus directed vectors.

module tb_sysid_regbank_uptime;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sysid_regbank_uptime #(
        .SYSID_ID        (32'h58D9_5B21),
        .SYSID_TIMESTAMP (32'h5A00_0001),
        .BUILD_INFO      (32'h0001_0000),
        .SCRATCH_RESET   (32'h0000_0000),
        .UPTIME_W        (64),
        .PRESCALE        (4)
    ) dut_a (
        .clock         (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (rdata_a),
        .readdatavalid (rvalid_a)
    );

    sysid_regbank_uptime #(
        .SYSID_ID        (32'hCAFE_0002),
        .SYSID_TIMESTAMP (32'h0000_1234),
        .BUILD_INFO      (32'h0002_0005),
        .SCRATCH_RESET   (32'h5555_AAAA),
        .UPTIME_W        (40),
        .PRESCALE        (1)
    ) dut_b (
        .clock         (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (rdata_b),
        .readdatavalid (rvalid_b)
    );

    // ---------------- reference model ----------------
    // Uptime is derived from the number of enabled cycles since the last
    // clear: ticks = cycles / PRESCALE, reduced modulo 2^UPTIME_W.
    longint unsigned m_ecyc [2];
    logic            m_en   [2];
    logic [31:0]     m_scr  [2];
    logic [31:0]     m_sh   [2];
    logic [31:0]     m_d    [2];
    logic            m_v    [2];

    function automatic longint unsigned ps(int i);
        return (i == 0) ? 64'd4 : 64'd1;
    endfunction

    function automatic int wd(int i);
        return (i == 0) ? 64 : 40;
    endfunction

    function automatic logic [31:0] scr_rst(int i);
        return (i == 0) ? 32'h0 : 32'h5555_AAAA;
    endfunction

    function automatic logic [31:0] ident(int i, logic [2:0] a);
        logic [31:0] t [3];
        if (i == 0) begin
            t[0] = 32'h58D9_5B21; t[1] = 32'h5A00_0001; t[2] = 32'h0001_0000;
        end else begin
            t[0] = 32'hCAFE_0002; t[1] = 32'h0000_1234; t[2] = 32'h0002_0005;
        end
        return t[a];
    endfunction

    function automatic logic [63:0] m_cnt(int i);
        longint unsigned t;
        t = m_ecyc[i] / ps(i);
        if (wd(i) < 64) t = t & ((64'd1 << wd(i)) - 64'd1);
        return t;
    endfunction

    task automatic model_step();
        logic [63:0] c;
        logic        clear;
        logic        new_en;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_ecyc[i] = 0;
                m_en[i]   = 1'b1;
                m_scr[i]  = scr_rst(i);
                m_sh[i]   = 32'h0;
                m_d[i]    = 32'h0;
                m_v[i]    = 1'b0;
            end else begin
                c      = m_cnt(i);
                clear  = 1'b0;
                new_en = m_en[i];
                m_v[i] = read;
                if (read) begin
                    case (address)
                        3'd0, 3'd1, 3'd2: m_d[i] = ident(i, address);
                        3'd3: m_d[i] = m_scr[i];
                        3'd4: begin
                            m_d[i]  = c[31:0];
                            m_sh[i] = c[63:32];
                        end
                        3'd5: m_d[i] = m_sh[i];
                        3'd6: m_d[i] = {31'b0, m_en[i]};
                        default: m_d[i] = 32'h0;
                    endcase
                end else if (write) begin
                    if (address == 3'd3) m_scr[i] = writedata;
                    if (address == 3'd6) begin
                        clear  = writedata[1];
                        new_en = writedata[0];
                    end
                end
                if (clear) m_ecyc[i] = 0;
                else if (m_en[i]) m_ecyc[i] = m_ecyc[i] + 1;
                m_en[i] = new_en;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model advances at the edge, outputs compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("valid_a", {31'b0, rvalid_a}, {31'b0, m_v[0]});
        check("data_a", rdata_a, m_d[0]);
        check("valid_b", {31'b0, rvalid_b}, {31'b0, m_v[1]});
        check("data_b", rdata_b, m_d[1]);
    endtask

    task automatic bus(input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] d);
        read = r; write = w; address = a; writedata = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    typedef struct packed {
        logic        r;
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [16];

    initial begin
        reset_n = 1'b0; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 32'h0;
        cycle();
        cycle();
        reset_n = 1'b1;

        // Prescaled uptime from reset, then freeze.
        idle(40);
        bus(1'b1, 1'b0, 3'd4, 32'h0);
        check("up_a_40", rdata_a, 32'd10);
        check("up_b_40", rdata_b, 32'd40);
        bus(1'b0, 1'b1, 3'd6, 32'h0);
        idle(100);
        bus(1'b1, 1'b0, 3'd4, 32'h0);
        check("frozen_a", rdata_a, 32'd10);
        check("frozen_b", rdata_b, 32'd42);
        bus(1'b0, 1'b1, 3'd6, 32'h1);

        // Directed vectors against instance A constants.
        tbl[0]  = {1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h58D9_5B21};
        tbl[1]  = {1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0};
        tbl[2]  = {1'b1, 1'b0, 3'd1, 32'h0, 1'b1, 32'h5A00_0001};
        tbl[3]  = {1'b1, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0001_0000};
        tbl[4]  = {1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[5]  = {1'b1, 1'b0, 3'd3, 32'h0, 1'b1, 32'hDEAD_BEEF};
        tbl[6]  = {1'b1, 1'b1, 3'd3, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        tbl[7]  = {1'b1, 1'b0, 3'd3, 32'h0, 1'b1, 32'hDEAD_BEEF};
        tbl[8]  = {1'b1, 1'b0, 3'd7, 32'h0, 1'b1, 32'h0};
        tbl[9]  = {1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[10] = {1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h58D9_5B21};
        tbl[11] = {1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[12] = {1'b0, 1'b1, 3'd6, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tbl[13] = {1'b1, 1'b0, 3'd6, 32'h0, 1'b1, 32'h0};
        tbl[14] = {1'b0, 1'b1, 3'd6, 32'h0000_0001, 1'b0, 32'h0};
        tbl[15] = {1'b1, 1'b0, 3'd6, 32'h0, 1'b1, 32'h1};
        for (int v = 0; v < 16; v++) begin
            bus(tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d);
            check($sformatf("vec%0d_valid", v), {31'b0, rvalid_a},
                  {31'b0, tbl[v].ev});
            if (tbl[v].ev) check($sformatf("vec%0d_data", v), rdata_a, tbl[v].ed);
        end

        // Reset with a read in flight, then scratch reset value.
        read = 1'b1; address = 3'd0; write = 1'b0;
        reset_n = 1'b0;
        cycle();
        check("rst_valid", {31'b0, rvalid_a}, 32'h0);
        check("rst_data", rdata_a, 32'h0);
        reset_n = 1'b1;
        bus(1'b1, 1'b0, 3'd3, 32'h0);
        check("scr_rst_a", rdata_a, 32'h0);
        check("scr_rst_b", rdata_b, 32'h5555_AAAA);

        // Clear with enable at every prescaler phase, incl. tick-due.
        for (int k = 0; k < 4; k++) begin
            idle(k);
            bus(1'b0, 1'b1, 3'd6, 32'h3);
            bus(1'b1, 1'b0, 3'd4, 32'h0);
            check("clr_lo_a", rdata_a, 32'h0);
            check("clr_lo_b", rdata_b, 32'h0);
            bus(1'b1, 1'b0, 3'd6, 32'h0);
            check("clr_ctrl_a", rdata_a, 32'h1);
        end

        // Snapshot and wrap on the 40-bit instance.
        bus(1'b0, 1'b1, 3'd6, 32'h0);
        force dut_b.uptime = 40'h00_FFFF_FFFF;
        #1 release dut_b.uptime;
        m_ecyc[1] = 64'h0000_0000_FFFF_FFFF;
        bus(1'b1, 1'b0, 3'd4, 32'h0);
        check("snap_lo", rdata_b, 32'hFFFF_FFFF);
        bus(1'b0, 1'b1, 3'd6, 32'h1);
        idle(5);
        bus(1'b1, 1'b0, 3'd5, 32'h0);
        check("snap_hi", rdata_b, 32'h0);
        bus(1'b0, 1'b1, 3'd6, 32'h0);
        force dut_b.uptime = 40'hFF_FFFF_FFFF;
        #1 release dut_b.uptime;
        m_ecyc[1] = 64'h0000_00FF_FFFF_FFFF;
        bus(1'b1, 1'b0, 3'd4, 32'h0);
        check("max_lo", rdata_b, 32'hFFFF_FFFF);
        bus(1'b1, 1'b0, 3'd5, 32'h0);
        check("max_hi", rdata_b, 32'h0000_00FF);
        bus(1'b0, 1'b1, 3'd6, 32'h1);
        idle(1);
        bus(1'b1, 1'b0, 3'd4, 32'h0);
        check("wrap_lo", rdata_b, 32'h0);
        bus(1'b1, 1'b0, 3'd5, 32'h0);
        check("wrap_hi", rdata_b, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            int          op;
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            op = $urandom_range(0, 9);
            if (a == 3'd6 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if (a == 3'd6 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            reset_n = ($urandom_range(0, 199) != 0);
            bus(op < 5 || op == 9, op >= 5, a, d);
        end
        reset_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
